// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-to-1 packet-locked stream multiplexer with internal arbiter
// A channel keeps the grant until its last beat; the output stage is a single register slice.
module stream_mux_arb #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH-1:0]         in_last,
    output logic [NUM_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [$clog2(NUM_CH)-1:0] out_sel,
    input  logic                      out_ready
);
    localparam int SW = $clog2(NUM_CH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [SW-1:0]    grant_q;
    logic [SW-1:0]    grant_d;
    logic [SW-1:0]    rr_ptr_q;
    logic [SW-1:0]    rr_ptr_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [SW-1:0]    out_sel_q;

    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             sel_valid;
    logic             arb_found;
    logic [SW:0]      arb_sum;
    logic [SW-1:0]    arb_idx;

    assign can_load = !out_valid_q || out_ready;
    assign xfer     = (state_q == S_LOCKED) && can_load && sel_valid;
    assign rr_ptr_d = (grant_q == SW'(NUM_CH - 1)) ? '0 : grant_q + SW'(1);

    // Search order starts at rr_ptr (round-robin) or at channel 0 (fixed priority).
    always_comb begin
        grant_d   = '0;
        arb_found = 1'b0;
        arb_sum   = '0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 1) begin
                arb_idx = SW'(k);
            end else begin
                arb_sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
                if (arb_sum >= (SW+1)'(NUM_CH)) begin
                    arb_sum = arb_sum - (SW+1)'(NUM_CH);
                end
                arb_idx = arb_sum[SW-1:0];
            end
            if (!arb_found && in_valid[arb_idx]) begin
                grant_d   = arb_idx;
                arb_found = 1'b1;
            end
        end
    end

    // Ready depends only on state and downstream space, never on in_valid.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        in_ready  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == SW'(c)) begin
                sel_data    = in_data[c*WIDTH +: WIDTH];
                sel_last    = in_last[c];
                sel_valid   = in_valid[c];
                in_ready[c] = (state_q == S_LOCKED) && can_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            if (xfer) begin
                out_data_q  <= sel_data;
                out_last_q  <= sel_last;
                out_sel_q   <= grant_q;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (|in_valid) begin
                        grant_q <= grant_d;
                        state_q <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (xfer && sel_last) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
